toeplitz_hash: RTL

TOEPLITZ_HASH -- requirements
Module: toeplitz_hash

---
 rtl/toeplitz_pkg.sv | 27 ++
 rtl/hash_out_serializer.sv | 41 ++++
 rtl/toeplitz_hash.sv | 130 +++++++++++++
 3 files changed

// File: rtl/toeplitz_pkg.sv
// Shared constants and FSM state encoding for the Toeplitz hash block.
package toeplitz_pkg;

  localparam int SEED_W    = 3072;
  localparam int IN_BITS   = 2048;
  localparam int OUT_BITS  = 1024;
  localparam int WORD_W    = 32;
  localparam int IN_WORDS  = 64;
  localparam int OUT_WORDS = 32;

  localparam int BIT_CNT_W  = $clog2(WORD_W);
  localparam int WORD_CNT_W = $clog2(IN_WORDS);
  localparam int OUT_IDX_W  = $clog2(OUT_WORDS);

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(IN_WORDS - 1);
  localparam logic [OUT_IDX_W-1:0]  LAST_OUT  = OUT_IDX_W'(OUT_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_WORD,
    PROC,
    OUT
  } state_e;

endpackage

// File: rtl/hash_out_serializer.sv
// Presents the 1024-bit accumulator as 32 words over a valid/ready handshake,
// lowest word first; the word index only moves on an accepted transfer.
module hash_out_serializer
  import toeplitz_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                active_i,
  input  logic [OUT_BITS-1:0] acc_i,
  input  logic                hash_ready_i,
  output logic                hash_valid_o,
  output logic [WORD_W-1:0]   hash_out_o,
  output logic                done_o
);

  logic [OUT_IDX_W-1:0] k_q, k_d;

  always_comb begin
    hash_valid_o = active_i;
    hash_out_o   = '0;
    k_d          = k_q;
    done_o       = 1'b0;
    if (active_i) begin
      hash_out_o = acc_i[{k_q, {BIT_CNT_W{1'b0}}} +: WORD_W];
      if (hash_ready_i) begin
        // Index wraps naturally to 0 after the last word.
        k_d    = k_q + 1'b1;
        done_o = (k_q == LAST_OUT);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/toeplitz_hash.sv
// Bit-serial Toeplitz hash: 2048-bit key block in, 1024-bit hash out over GF(2).
// Optional macro SEED_REUSE_EN keeps a shadow seed so blocks can repeat without a new handshake.
module toeplitz_hash
  import toeplitz_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst,
  input  logic [SEED_W-1:0] seed,
  input  logic              shift_en,
  output logic              shift_ack,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [WORD_W-1:0] hash_out,
  output logic              hash_valid,
  input  logic              hash_ready
);

  state_e                  state_q, state_d;
  logic [SEED_W-1:0]       sreg_q, sreg_d;
  logic [OUT_BITS-1:0]     acc_q, acc_d;
  logic [WORD_W-1:0]       din_q, din_d;
  logic [BIT_CNT_W-1:0]    bit_q, bit_d;
  logic [WORD_CNT_W-1:0]   word_q, word_d;
  logic                    ser_active;
  logic                    ser_done;

`ifdef SEED_REUSE_EN
  logic [SEED_W-1:0]       shadow_q;
`endif

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    acc_d      = acc_q;
    din_d      = din_q;
    bit_d      = bit_q;
    word_d     = word_q;
    shift_ack  = 1'b0;
    data_ready = 1'b0;
    ser_active = 1'b0;
    case (state_q)
      IDLE: begin
        if (shift_en) state_d = CAPTURE;
      end
      CAPTURE: begin
        shift_ack = 1'b1;
        sreg_d    = seed;
        acc_d     = '0;
        word_d    = '0;
        bit_d     = '0;
        state_d   = WAIT_WORD;
      end
      WAIT_WORD: begin
        data_ready = 1'b1;
        if (data_valid) begin
          din_d   = data_in;
          bit_d   = '0;
          state_d = PROC;
        end
      end
      PROC: begin
        // Each input bit selects the current 1024-bit window of the seed.
        if (din_q[0]) acc_d = acc_q ^ sreg_q[OUT_BITS-1:0];
        sreg_d = sreg_q >> 1;
        din_d  = din_q >> 1;
        bit_d  = bit_q + 1'b1;
        if (bit_q == LAST_BIT) begin
          word_d  = word_q + 1'b1;
          state_d = (word_q == LAST_WORD) ? OUT : WAIT_WORD;
        end
      end
      OUT: begin
        ser_active = 1'b1;
        if (ser_done) begin
`ifdef SEED_REUSE_EN
          sreg_d  = shadow_q;
          acc_d   = '0;
          word_d  = '0;
          bit_d   = '0;
          state_d = WAIT_WORD;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      din_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      din_q   <= din_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
    end
  end

`ifdef SEED_REUSE_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (state_q == CAPTURE) begin
      shadow_q <= seed;
    end
  end
`endif

  hash_out_serializer u_ser (
    .clk_i        (clk_in),
    .rst_i        (rst),
    .active_i     (ser_active),
    .acc_i        (acc_q),
    .hash_ready_i (hash_ready),
    .hash_valid_o (hash_valid),
    .hash_out_o   (hash_out),
    .done_o       (ser_done)
  );

endmodule
